// File: rtl/uart_pkg.sv
// Shared UART constants: baud select codes, counter width and the divisor function.
package uart_pkg;

  localparam int unsigned CNT_W_DFLT = 19;
  localparam int unsigned NUM_BAUD   = 12;

  localparam logic [3:0] BAUD_300    = 4'd0;
  localparam logic [3:0] BAUD_1200   = 4'd1;
  localparam logic [3:0] BAUD_2400   = 4'd2;
  localparam logic [3:0] BAUD_4800   = 4'd3;
  localparam logic [3:0] BAUD_9600   = 4'd4;
  localparam logic [3:0] BAUD_19200  = 4'd5;
  localparam logic [3:0] BAUD_38400  = 4'd6;
  localparam logic [3:0] BAUD_57600  = 4'd7;
  localparam logic [3:0] BAUD_115200 = 4'd8;
  localparam logic [3:0] BAUD_230400 = 4'd9;
  localparam logic [3:0] BAUD_460800 = 4'd10;
  localparam logic [3:0] BAUD_921600 = 4'd11;

  function automatic int unsigned baud_rate(input logic [3:0] code);
    case (code)
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_2400:   return 2400;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      BAUD_115200: return 115200;
      BAUD_230400: return 230400;
      BAUD_460800: return 460800;
      BAUD_921600: return 921600;
      default:     return 0;
    endcase
  endfunction

  // Clock cycles per bit, rounded half-up; 0 for unsupported codes.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [3:0] code);
    int unsigned rate;
    rate = baud_rate(code);
    if (rate == 0) return 0;
    return (clk_hz + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/baud_rate_lut.sv
// Baud code to {valid, divisor-1}; the table is folded to constants at elaboration.
module baud_rate_lut import uart_pkg::*; #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned CNT_W  = CNT_W_DFLT
) (
  input  logic [3:0]       code,
  output logic             valid_c,
  output logic [CNT_W-1:0] div_m1_c
);

  logic [CNT_W-1:0] tbl [NUM_BAUD];

  for (genvar g = 0; g < NUM_BAUD; g++) begin : g_tbl
    assign tbl[g] = CNT_W'(baud_div(CLK_HZ, 4'(g)) - 1);
  end

  always_comb begin
    valid_c  = (code < 4'(NUM_BAUD));
    div_m1_c = '0;
    if (valid_c) div_m1_c = tbl[code];
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud divide counter with bit/mid-bit strobes, boundary-aligned rate switching,
// RX phase restart and unsupported-code flag.
module baud_tick_gen import uart_pkg::*; #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned CNT_W      = CNT_W_DFLT,
  parameter logic [3:0]  RESET_BAUD = BAUD_300
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             restart,
  input  logic [3:0]       baud,
  output logic             bit_tick,
  output logic             mid_tick,
  output logic             baud_err,
  output logic [CNT_W-1:0] div_out
);

  localparam logic [CNT_W-1:0] RST_DIV_M1 = CNT_W'(baud_div(CLK_HZ, RESET_BAUD) - 1);

  if (64'(baud_div(CLK_HZ, BAUD_300)) - 64'd1 >= (64'd1 << CNT_W)) begin : g_cnt_w_too_small
    $error("CNT_W cannot hold the slowest divisor");
  end
  if (RESET_BAUD >= 4'(NUM_BAUD)) begin : g_bad_reset_baud
    $error("RESET_BAUD is not a supported code");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             bit_tick_q, bit_tick_d;
  logic             mid_tick_q, mid_tick_d;
  logic             baud_err_q, baud_err_d;

  logic             lut_valid_c;
  logic [CNT_W-1:0] lut_div_c;
  logic [CNT_W:0]   div_full_c;
  logic [CNT_W-1:0] mid_cnt_c;

  baud_rate_lut #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_lut (
    .code     (baud),
    .valid_c  (lut_valid_c),
    .div_m1_c (lut_div_c)
  );

  // Mid-bit compare point (DIV >> 1) - 1, computed one bit wider so DIV never overflows.
  always_comb begin
    div_full_c = {1'b0, div_cur_q} + (CNT_W+1)'(1);
    mid_cnt_c  = CNT_W'(div_full_c >> 1) - CNT_W'(1);
  end

  // Divisor only moves at a period boundary, restart or while idle, so periods are never cut.
  always_comb begin
    cnt_d      = cnt_q;
    div_cur_d  = div_cur_q;
    bit_tick_d = 1'b0;
    mid_tick_d = 1'b0;
    pend_div_d = lut_valid_c ? lut_div_c : pend_div_q;
    baud_err_d = ~lut_valid_c;

    if (!en || restart) begin
      cnt_d     = '0;
      div_cur_d = pend_div_q;
    end else if (cnt_q == div_cur_q) begin
      cnt_d      = '0;
      bit_tick_d = 1'b1;
      div_cur_d  = pend_div_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (en && !restart && (cnt_q == mid_cnt_c)) mid_tick_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      div_cur_q  <= RST_DIV_M1;
      pend_div_q <= RST_DIV_M1;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
      baud_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_cur_q  <= div_cur_d;
      pend_div_q <= pend_div_d;
      bit_tick_q <= bit_tick_d;
      mid_tick_q <= mid_tick_d;
      baud_err_q <= baud_err_d;
    end
  end

  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
  assign baud_err = baud_err_q;
  assign div_out  = div_cur_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen at 100 MHz; tick positions are counted in clocks
// from the cycle in which the counter starts a period at 0.
module tb_baud_tick_gen;

  localparam int D11   = 109;     // 921600 baud
  localparam int D10   = 217;     // 460800 baud
  localparam int D_RST = 333333;  // 300 baud

  logic        clk = 1'b0;
  logic        reset_n, en, restart;
  logic [3:0]  baud;
  logic        bit_tick, mid_tick, baud_err;
  logic [18:0] div_out;

  always #5 clk = ~clk;

  baud_tick_gen #(
    .CLK_HZ     (100_000_000),
    .CNT_W      (19),
    .RESET_BAUD (4'b0000)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .en       (en),
    .restart  (restart),
    .baud     (baud),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .baud_err (baud_err),
    .div_out  (div_out)
  );

  int n_checks = 0;
  int n_errors = 0;
  int t;
  int bit_pos[$];
  int mid_pos[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    t++;
    if (bit_tick === 1'b1) bit_pos.push_back(t);
    if (mid_tick === 1'b1) mid_pos.push_back(t);
  endtask

  task automatic run_to(input int n);
    while (t < n) step();
  endtask

  task automatic clear_q();
    bit_pos.delete();
    mid_pos.delete();
  endtask

  task automatic mark();
    t = 0;
    clear_q();
  endtask

  initial begin
    reset_n = 1'b0; en = 1'b0; restart = 1'b0; baud = 4'd11; t = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_bit", bit_tick, 0);
    check("rst_mid", mid_tick, 0);
    check("rst_err", baud_err, 0);
    check("rst_div", div_out, D_RST - 1);
    reset_n = 1'b1;
    repeat (3) step();
    check("idle_div", div_out, D11 - 1);

    // Steady 921600 baud from enable
    en = 1'b1;
    mark();
    run_to(330);
    check("run_nbit", bit_pos.size(), 3);
    check("run_bit0", q_at(bit_pos, 0), D11);
    check("run_bit1", q_at(bit_pos, 1), 2 * D11);
    check("run_bit2", q_at(bit_pos, 2), 3 * D11);
    check("run_nmid", mid_pos.size(), 3);
    check("run_mid0", q_at(mid_pos, 0), 54);
    check("run_mid1", q_at(mid_pos, 1), D11 + 54);

    // Rate change at cnt = 40 of the period that began at t = 327
    run_to(367);
    baud = 4'd10;
    clear_q();
    run_to(435);
    check("rc_div_old", div_out, D11 - 1);
    run_to(436);
    check("rc_tick_old", bit_tick, 1);
    check("rc_div_new", div_out, D10 - 1);
    run_to(660);
    check("rc_nbit", bit_pos.size(), 2);
    check("rc_bit0", q_at(bit_pos, 0), 327 + D11);
    check("rc_bit1", q_at(bit_pos, 1), 327 + D11 + D10);
    check("rc_nmid", mid_pos.size(), 2);
    check("rc_mid0", q_at(mid_pos, 0), 327 + 54);
    check("rc_mid1", q_at(mid_pos, 1), 327 + D11 + 108);

    // Disable for 20 cycles mid-period, then re-enable
    baud = 4'd11;
    en = 1'b0;
    clear_q();
    run_to(680);
    check("dis_nbit", bit_pos.size(), 0);
    check("dis_nmid", mid_pos.size(), 0);
    check("dis_div", div_out, D11 - 1);
    en = 1'b1;
    mark();
    run_to(120);
    check("ren_bit", q_at(bit_pos, 0), D11);
    check("ren_mid", q_at(mid_pos, 0), 54);

    // Unsupported code while running at 921600
    check("inv_err_pre", baud_err, 0);
    baud = 4'd12;
    step();
    check("inv_err_hi", baud_err, 1);
    clear_q();
    run_to(230);
    check("inv_nbit", bit_pos.size(), 1);
    check("inv_bit", q_at(bit_pos, 0), 2 * D11);
    check("inv_mid", q_at(mid_pos, 0), D11 + 54);
    check("inv_div", div_out, D11 - 1);
    check("inv_err_hold", baud_err, 1);
    baud = 4'd11;
    step();
    check("inv_err_lo", baud_err, 0);

    // Restart at cnt = 50 (period began at t = 218)
    run_to(268);
    restart = 1'b1;
    mark();
    step();
    restart = 1'b0;
    run_to(121);
    check("rs_nbit", bit_pos.size(), 1);
    check("rs_bit", q_at(bit_pos, 0), 1 + D11);
    check("rs_nmid", mid_pos.size(), 1);
    check("rs_mid", q_at(mid_pos, 0), 1 + 54);

    // Restart coinciding with terminal count (cnt = 108 after t = 218)
    run_to(218);
    restart = 1'b1;
    mark();
    step();
    restart = 1'b0;
    run_to(121);
    check("rst_tc_nbit", bit_pos.size(), 1);
    check("rst_tc_bit", q_at(bit_pos, 0), 1 + D11);
    check("rst_tc_mid", q_at(mid_pos, 0), 1 + 54);

    // Asynchronous reset while mid_tick is high
    run_to(1 + D11 + 54);
    check("pre_rst_mid", mid_tick, 1);
    reset_n = 1'b0;
    baud = 4'd12;
    #1;
    check("arst_mid", mid_tick, 0);
    check("arst_bit", bit_tick, 0);
    check("arst_div", div_out, D_RST - 1);
    repeat (2) @(posedge clk);
    #1;
    check("arst_err", baud_err, 0);
    baud = 4'd11;
    reset_n = 1'b1;
    mark();
    run_to(300);
    check("post_rst_nbit", bit_pos.size(), 0);
    check("post_rst_nmid", mid_pos.size(), 0);
    check("post_rst_div", div_out, D_RST - 1);

    // Restart picks up the pending rate without waiting out the 300-baud period
    restart = 1'b1;
    mark();
    step();
    restart = 1'b0;
    run_to(121);
    check("post_rs_div", div_out, D11 - 1);
    check("post_rs_bit", q_at(bit_pos, 0), 1 + D11);
    check("post_rs_mid", q_at(mid_pos, 0), 1 + 54);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
